// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with enable and an auto-scan mode.
// Latency: 1 clk from A/E/mode to Y; scan steps every STEP_DIV clks, wrap pulses for 1 clk.
// Backpressure: none; free-running, outputs update every edge.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   E      - enable; 0 forces Y to zero (idx retained)
//   mode   - 0 = direct decode of A, 1 = auto-scan
//   A      - select (direct) or load value (scan)
//   load   - scan mode only: jump idx to A
//   dir    - (only with DECODER_SCAN_BIDIR_EN) 0 = scan up, 1 = scan down
//   Y      - registered one-hot output (or zero)
//   idx    - current index
//   wrap   - one-cycle pulse when the scan index rolls over
//
// Optional feature macro: DECODER_SCAN_BIDIR_EN (adds the dir port / down-scan).

module decoder_n_scan #(
   parameter int N        = 2,
   parameter int STEP_DIV = 4,
   parameter int DIV_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               E,
   input  logic               mode,
   input  logic [N-1:0]       A,
   input  logic               load,
`ifdef DECODER_SCAN_BIDIR_EN
   input  logic               dir,
`endif
   output logic [(1<<N)-1:0]  Y,
   output logic [N-1:0]       idx,
   output logic               wrap
);

   localparam int M = 1 << N;
   localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [M-1:0]       r_y;
   logic [N-1:0]       r_idx;
   logic [DIV_W-1:0]   r_dwell;
   logic               r_wrap;

   logic [M-1:0]       w_y_nxt;
   logic [N-1:0]       w_idx_nxt;
   logic [DIV_W-1:0]   w_dwell_nxt;
   logic               w_wrap_nxt;
   logic [DIV_W-1:0]   w_dwell_cur;
   logic               w_down;
   logic [N-1:0]       w_idx_step;
   logic               w_step_wraps;

   function automatic logic [M-1:0] onehot(input logic [N-1:0] sel);
      logic [M-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

`ifdef DECODER_SCAN_BIDIR_EN
   assign w_down = dir;
`else
   assign w_down = 1'b0;
`endif

   // Next index for a scan step and whether that step crosses the sweep boundary.
   always_comb begin
      w_idx_step   = r_idx;
      w_step_wraps = 1'b0;
      if (w_down) begin
         w_idx_step   = r_idx - N'(1);
         w_step_wraps = (r_idx == '0);
      end else begin
         w_idx_step   = r_idx + N'(1);
         w_step_wraps = (r_idx == '1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_y     <= '0;
         r_idx   <= '0;
         r_dwell <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_y     <= w_y_nxt;
         r_idx   <= w_idx_nxt;
         r_dwell <= w_dwell_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = IDLE;
      w_y_nxt     = '0;
      w_idx_nxt   = r_idx;
      w_dwell_nxt = '0;
      w_wrap_nxt  = 1'b0;
      // The dwell count only carries over while staying in SCAN; any entry restarts it.
      w_dwell_cur = (r_state == SCAN) ? r_dwell : '0;

      if (!E) begin
         w_state_nxt = IDLE;
      end else if (!mode) begin
         w_state_nxt = DIRECT;
      end else begin
         w_state_nxt = SCAN;
      end

      case (w_state_nxt)
         IDLE: begin
            // Y cleared, idx retained so a later scan resumes where it stopped.
         end
         DIRECT: begin
            w_idx_nxt = A;
            w_y_nxt   = onehot(A);
         end
         SCAN: begin
            if (load) begin
               w_idx_nxt = A;
               w_y_nxt   = onehot(A);
            end else if (w_dwell_cur == DWELL_LAST) begin
               w_idx_nxt  = w_idx_step;
               w_y_nxt    = onehot(w_idx_step);
               w_wrap_nxt = w_step_wraps;
            end else begin
               w_dwell_nxt = w_dwell_cur + DIV_W'(1);
               w_y_nxt     = onehot(r_idx);
            end
         end
         default: begin
         end
      endcase
   end

   assign Y    = r_y;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan: scoreboard bench for decoder_n_scan (N=2/STEP_DIV=3 and N=3/STEP_DIV=1).
// Latency: expected values queued at drive time, compared 1 clk later.
// Backpressure: none.

module tb_decoder_n_scan;

   localparam int SD = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       E = 1'b0, mode = 1'b0, load = 1'b0;
   logic [1:0] A = '0;
   logic [3:0] Y;
   logic [1:0] idx;
   logic       wrap;

   logic       E2 = 1'b0, mode2 = 1'b0, load2 = 1'b0;
   logic [2:0] A2 = '0;
   logic [7:0] Y2;
   logic [2:0] idx2;
   logic       wrap2;

   always #5 clk = ~clk;

   decoder_n_scan #(.N(2), .STEP_DIV(SD), .DIV_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .E     (E),
      .mode  (mode),
      .A     (A),
      .load  (load),
`ifdef DECODER_SCAN_BIDIR_EN
      .dir   (1'b0),
`endif
      .Y     (Y),
      .idx   (idx),
      .wrap  (wrap)
   );

   decoder_n_scan #(.N(3), .STEP_DIV(1), .DIV_W(16)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .E     (E2),
      .mode  (mode2),
      .A     (A2),
      .load  (load2),
`ifdef DECODER_SCAN_BIDIR_EN
      .dir   (1'b0),
`endif
      .Y     (Y2),
      .idx   (idx2),
      .wrap  (wrap2)
   );

   typedef struct packed {
      logic [3:0] y;
      logic [1:0] idx;
      logic       wrap;
   } exp_t;

   exp_t q[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference state for the N=2 instance.
   logic [3:0] m_y    = '0;
   logic [1:0] m_idx  = '0;
   int         m_dwell = 0;
   logic       m_wrap = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_y = '0; m_idx = '0; m_dwell = 0; m_wrap = 1'b0;
   endtask

   // Spec-level behaviour of one clock edge in terms of state, with the given inputs.
   task automatic model_step(input logic e, input logic md, input logic [1:0] a, input logic ld);
      exp_t x;
      m_wrap = 1'b0;
      if (!e) begin
         m_y = '0;
         m_dwell = 0;
      end else if (!md || ld) begin
         m_idx = a;
         m_y = 4'b0001 << a;
         m_dwell = 0;
      end else if (m_dwell == SD - 1) begin
         m_wrap = (m_idx == 2'd3);
         m_idx = m_idx + 2'd1;
         m_y = 4'b0001 << m_idx;
         m_dwell = 0;
      end else begin
         m_dwell = m_dwell + 1;
         m_y = 4'b0001 << m_idx;
      end
      x.y = m_y; x.idx = m_idx; x.wrap = m_wrap;
      q.push_back(x);
   endtask

   // Drive at the falling edge; the following rising edge samples these inputs.
   task automatic drive(input logic e, input logic md, input logic [1:0] a, input logic ld);
      @(negedge clk);
      E = e; mode = md; A = a; load = ld;
      model_step(e, md, a, ld);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("Y",    32'(Y),    32'(x.y));
         chk("idx",  32'(idx),  32'(x.idx));
         chk("wrap", 32'(wrap), 32'(x.wrap));
      end
   end

   initial begin
      // 1. reset, then direct decode
      repeat (2) @(negedge clk);
      chk("rst_y",    32'(Y),    32'h0);
      chk("rst_idx",  32'(idx),  32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      rst_n = 1'b1;
      model_reset();
      for (int a = 0; a < 4; a++) drive(1'b1, 1'b0, 2'(a), 1'b0);

      // 2. disabled: Y stays zero, idx holds
      for (int a = 0; a < 4; a++) drive(1'b0, 1'b0, 2'(a), 1'b1);

      // 3. full sweep from idx=0 including the wrap
      drive(1'b1, 1'b0, 2'd0, 1'b0);
      repeat (13) drive(1'b1, 1'b1, 2'd0, 1'b0);

      // 4. load at idx=1, dwell=1
      drive(1'b1, 1'b0, 2'd0, 1'b0);
      repeat (4) drive(1'b1, 1'b1, 2'd0, 1'b0);
      drive(1'b1, 1'b1, 2'd3, 1'b1);
      @(posedge clk); #2;
      chk("t4_load_y", 32'(Y), 32'h8);
      repeat (4) drive(1'b1, 1'b1, 2'd0, 1'b0);

      // load coinciding with a step boundary wins
      drive(1'b1, 1'b0, 2'd1, 1'b0);
      repeat (2) drive(1'b1, 1'b1, 2'd0, 1'b0);
      drive(1'b1, 1'b1, 2'd0, 1'b1);
      repeat (3) drive(1'b1, 1'b1, 2'd0, 1'b0);

      // E dropping mid-scan, then resume from retained idx
      repeat (2) drive(1'b1, 1'b1, 2'd0, 1'b0);
      repeat (2) drive(1'b0, 1'b1, 2'd0, 1'b0);
      repeat (4) drive(1'b1, 1'b1, 2'd0, 1'b0);

      // scan -> direct discards the pending step
      drive(1'b1, 1'b0, 2'd2, 1'b0);
      drive(1'b1, 1'b1, 2'd0, 1'b0);

      // 5. async reset between edges while idx=2
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t5_y",    32'(Y),    32'h0);
      chk("t5_idx",  32'(idx),  32'h0);
      chk("t5_wrap", 32'(wrap), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0);

      // 6. N=3, STEP_DIV=1: advances every edge, wraps every 8th
      @(negedge clk);
      E2 = 1'b1; mode2 = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         chk("t6_y",    32'(Y2),    32'(8'h01 << (k % 8)));
         chk("t6_idx",  32'(idx2),  32'(k % 8));
         chk("t6_wrap", 32'(wrap2), 32'((k % 8) == 0));
      end

      @(negedge clk);
      if (q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_drain got=%0d exp=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
